ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Drives the configuration-chain input (ccff_head) of a tile's switch/connection-block memory chain from a word-oriented bitstream source.
- Accepts words through a valid/ready handshake, serializes them MSB-first, and emits a shift-enable that the top level uses to gate the fabric's prog_clk.
- Counts bits, stops after exactly CHAIN_LEN bits, and reports completion.
- Sits between the bitstream fetch logic and the ccff_head of the first tile in the chain.

Parameters:
- WORD_W, 32, input word width in bits (>=1).
- CHAIN_LEN, 36, total configuration bits in the chain (>=1); default matches 18 two-bit mux memories.
- CNT_W, $clog2(CHAIN_LEN+1), bit-counter width (derived, localparam).

Ports:
- prog_clk, in, 1, programming clock; all state updates on its rising edge.
- pReset, in, 1, synchronous active-low reset.
- start, in, 1, begins a load when sampled high in IDLE.
- cfg_data, in, WORD_W, bitstream word; bit WORD_W-1 is shifted first.
- cfg_valid, in, 1, cfg_data valid.
- cfg_ready, out, 1, loader accepts a word this cycle.
- ccff_head, out, 1, serial bit into the chain.
- ccff_shift_en, out, 1, chain shifts on the prog_clk edge where this is high.
- ccff_tail, in, 1, chain output (used only with CCFF_READBACK_EN).
- busy, out, 1, high in LOAD or SHIFT.
- done, out, 1, high in DONE.
- bit_count, out, CNT_W, bits shifted so far in the current load.

Behaviour:
- Reset (pReset==0 at a clock edge): state=IDLE, cfg_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, bit_count=0, shift register and word-bit counter=0. Reset overrides every other input. Reset mid-load abandons the load with no further shift_en; the chain keeps whatever partial contents it has.
- All outputs are registered.
- States:
  - IDLE: start=1 -> LOAD, bit_count<=0.
  - LOAD: cfg_ready=1 (combinational from state). On cfg_valid&cfg_ready, capture cfg_data, set word_left=min(WORD_W, CHAIN_LEN-bit_count), then -> SHIFT.
  - SHIFT: cfg_ready=0. Each cycle: ccff_head<=shreg[WORD_W-1]; ccff_shift_en<=1; shreg<<=1; bit_count++; word_left--. When word_left reaches 0: if bit_count==CHAIN_LEN -> DONE, else -> LOAD.
  - DONE: done=1, shift_en=0. start=1 -> LOAD (new load, bit_count<=0, done<=0).
- Latency and timing:
  - First bit: ccff_shift_en rises the cycle after the accepting handshake.
  - A word of k bits yields exactly k consecutive shift_en cycles.
  - There is a one-cycle LOAD gap per word minimum; shift_en=0 while in LOAD.
- Last word: only the top (CHAIN_LEN mod WORD_W) bits are used (or all WORD_W if the remainder is 0). The low bits are discarded.
- ccff_head holds its last value whenever shift_en=0.
- start is ignored in LOAD and SHIFT. cfg_valid is ignored outside LOAD.
- Total shift_en cycles per load is exactly CHAIN_LEN. bit_count never exceeds CHAIN_LEN.

Optional Feature:
- CCFF_READBACK_EN
- Defined:
  - Adds outputs rb_data[WORD_W] and rb_valid[1], both reset to 0.
  - On every cycle with ccff_shift_en=1, ccff_tail is shifted into rb_shreg LSB-side; these are the chain's previous contents, oldest first.
  - After every WORD_W samples, or at the final bit of the load (zero-padded in the low bits so the first sample is at bit WORD_W-1), rb_data<=captured word and rb_valid pulses for 1 cycle.
  - There is no backpressure.
- Undefined: ports are absent and ccff_tail is unused.

Test Plan:
- Reset, then hold pReset=0 for 3 cycles with start=1 -> all outputs 0, state IDLE. Release -> stays IDLE until start.
- Default params; start; words 0xA5A5_F00F then 0xC000_0000 -> ccff_head sequence 1010_0101_1010_0101_1111_0000_0000_1111 then 1100. Exactly 36 shift_en cycles, bit_count=36, done=1, second word's low 28 bits discarded.
- cfg_valid withheld 5 cycles between words -> cfg_ready high throughout the wait, shift_en=0, ccff_head stable, bit_count=32 during the gap.
- pReset=0 while bit_count=17 -> next cycle shift_en=0, bit_count=0, IDLE. New start reloads 36 bits from scratch.
- start pulsed during SHIFT -> ignored; load completes at 36. start in DONE -> done clears, new load begins.
- CCFF_READBACK_EN, loop ccff_tail through a 36-bit shift-register model preloaded with 0x9_1234_5678 -> rb_valid pulses twice with rb_data=0x9123_4567, then 0x8000_0000.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words MSB-first into a tile's ccff configuration chain, stopping after CHAIN_LEN bits.
// Define CCFF_READBACK_EN to add capture of the chain's previous contents (rb_data/rb_valid) from ccff_tail.
module ccff_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 36
) (
    input  logic                           prog_clk,
    input  logic                           pReset,
    input  logic                           start,
    input  logic [WORD_W-1:0]              cfg_data,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    output logic                           ccff_head,
    output logic                           ccff_shift_en,
    input  logic                           ccff_tail,
    output logic                           busy,
    output logic                           done,
`ifdef CCFF_READBACK_EN
    output logic [WORD_W-1:0]              rb_data,
    output logic                           rb_valid,
`endif
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_LOAD  | cfg_ready high, waiting for the next word
    // S_SHIFT | one chain bit per cycle; ccff_shift_en high for each
    // S_DONE  | CHAIN_LEN bits loaded; start begins a new load

    localparam int CNT_W = $clog2(CHAIN_LEN+1);
    localparam int WL_W  = $clog2(WORD_W+1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t            state, state_n;
    logic [WORD_W-1:0] shreg;
    logic [WL_W-1:0]   word_left, word_left_n;
    logic [CNT_W-1:0]  remaining;
    logic              load_start, accept, shift_step, last_shift;

    assign remaining = CNT_W'(CHAIN_LEN) - bit_count;

    // Last word of a load only contributes the bits still owed to the chain.
    always_comb begin
        word_left_n = WL_W'(remaining);
        if (int'(remaining) >= WORD_W) word_left_n = WL_W'(WORD_W);
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset) state <= S_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n    = state;
        cfg_ready  = 1'b0;
        load_start = 1'b0;
        accept     = 1'b0;
        shift_step = 1'b0;
        last_shift = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n    = S_LOAD;
                    load_start = 1'b1;
                end
            end
            S_LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    accept  = 1'b1;
                    state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_step = 1'b1;
                if (word_left == WL_W'(1)) begin
                    last_shift = 1'b1;
                    state_n    = (bit_count == CNT_W'(CHAIN_LEN-1)) ? S_DONE : S_LOAD;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // ccff_shift_en is raised at the accepting edge so it is high exactly while in SHIFT.
    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bit_count     <= '0;
            shreg         <= '0;
            word_left     <= '0;
        end else begin
            busy <= (state_n == S_LOAD) || (state_n == S_SHIFT);
            done <= (state_n == S_DONE);
            if (load_start) bit_count <= '0;
            if (accept) begin
                ccff_head     <= cfg_data[WORD_W-1];
                shreg         <= cfg_data << 1;
                ccff_shift_en <= 1'b1;
                word_left     <= word_left_n;
            end
            if (shift_step) begin
                bit_count <= bit_count + CNT_W'(1);
                word_left <= word_left - WL_W'(1);
                if (last_shift) begin
                    ccff_shift_en <= 1'b0;
                end else begin
                    ccff_head <= shreg[WORD_W-1];
                    shreg     <= shreg << 1;
                end
            end
        end
    end

`ifdef CCFF_READBACK_EN
    localparam int RB_W = $clog2(WORD_W+1);

    logic [WORD_W-1:0] rb_shreg, rb_next;
    logic [WORD_W:0]   rb_wide;
    logic [RB_W-1:0]   rb_cnt, rb_n;
    logic              final_bit;

    assign rb_wide   = {rb_shreg, ccff_tail};
    assign rb_next   = rb_wide[WORD_W-1:0];
    assign rb_n      = rb_cnt + RB_W'(1);
    assign final_bit = last_shift && (state_n == S_DONE);

    // A short final word is left-justified so the oldest sample lands in the MSB.
    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            rb_shreg <= '0;
            rb_cnt   <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (load_start) rb_cnt <= '0;
            if (ccff_shift_en) begin
                rb_shreg <= rb_next;
                if (rb_n == RB_W'(WORD_W) || final_bit) begin
                    rb_data  <= rb_next << (WORD_W - int'(rb_n));
                    rb_valid <= 1'b1;
                    rb_cnt   <= '0;
                end else begin
                    rb_cnt <= rb_n;
                end
            end
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: expected chain bits and readback words are queued from a
// bit-level model of the load and popped by a monitor whenever the DUT shifts or presents readback.
module tb_ccff_chain_loader;
    localparam int WORD_W    = 32;
    localparam int CHAIN_LEN = 36;
    localparam int CNT_W     = $clog2(CHAIN_LEN+1);

    logic              prog_clk = 1'b0;
    logic              pReset = 1'b0;
    logic              start = 1'b0;
    logic [WORD_W-1:0] cfg_data = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done;
    logic [CNT_W-1:0]  bit_count;
`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;
`endif

    ccff_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .ccff_head(ccff_head),
        .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .busy(busy), .done(done),
`ifdef CCFF_READBACK_EN
        .rb_data(rb_data), .rb_valid(rb_valid),
`endif
        .bit_count(bit_count)
    );

    always #5 prog_clk = ~prog_clk;

    // Behavioural configuration chain: head enters bit 0, tail leaves from the top.
    logic [CHAIN_LEN-1:0] chain = 36'h9_1234_5678;
    always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    assign ccff_tail = chain[CHAIN_LEN-1];

    int                n_checks = 0;
    int                n_fail = 0;
    bit                exp_q[$];
    logic [WORD_W-1:0] rb_q[$];
    int                model_sent = 0;
    int                shift_base = 0;
    int                shift_total = 0;
    bit                mon_en = 1'b0;
    logic              rst_seen = 1'b1;
    logic              prev_head = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge prog_clk) rst_seen <= !pReset;

    always @(negedge prog_clk) begin
        if (mon_en) begin
            if (rst_seen) begin
                exp_q.delete();
                rb_q.delete();
            end else if (!ccff_shift_en) begin
                check("head_hold", ccff_head, prev_head);
            end
            if (ccff_shift_en) begin
                shift_total++;
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_shift: shift_en high with no bit owed");
                end else begin
                    check("ccff_head", ccff_head, exp_q.pop_front());
                end
            end
            check("bit_count_max", bit_count > CNT_W'(CHAIN_LEN), 0);
`ifdef CCFF_READBACK_EN
            if (!rst_seen && rb_valid) begin
                if (rb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_rb: rb_valid with data %0h", rb_data);
                end else begin
                    check("rb_data", rb_data, rb_q.pop_front());
                end
            end
`endif
        end
        prev_head = ccff_head;
    end

    task automatic begin_load();
        logic [WORD_W-1:0] w;
        int c;
        w = '0;
        c = 0;
        for (int i = CHAIN_LEN-1; i >= 0; i--) begin
            w = (w << 1) | WORD_W'(chain[i]);
            c++;
            if (c == WORD_W || i == 0) begin
                rb_q.push_back(w << (WORD_W - c));
                w = '0;
                c = 0;
            end
        end
        model_sent = 0;
        shift_base = shift_total;
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_ready", cfg_ready, 1);
        check("start_bit_count", bit_count, 0);
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w);
        int k;
        k = (CHAIN_LEN - model_sent < WORD_W) ? CHAIN_LEN - model_sent : WORD_W;
        for (int i = 0; i < k; i++) exp_q.push_back(w[WORD_W-1-i]);
        model_sent += k;
        cfg_data  = w;
        cfg_valid = 1'b1;
        for (int i = 0; i < 200 && !cfg_ready; i++) @(negedge prog_clk);
        if (!cfg_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: cfg_ready never rose");
        end
        @(negedge prog_clk);
        cfg_valid = 1'b0;
    endtask

    task automatic finish_load();
        for (int i = 0; i < 300 && !done; i++) @(negedge prog_clk);
        @(negedge prog_clk);
        check("done", done, 1);
        check("end_busy", busy, 0);
        check("end_bit_count", bit_count, CHAIN_LEN);
        check("shift_cycles", shift_total - shift_base, CHAIN_LEN);
        check("bits_left", exp_q.size(), 0);
`ifdef CCFF_READBACK_EN
        check("rb_left", rb_q.size(), 0);
`endif
    endtask

    task automatic random_load();
        begin_load();
        while (model_sent < CHAIN_LEN) begin
            repeat ($urandom_range(0, 3)) @(negedge prog_clk);
            send_word($urandom);
        end
        finish_load();
    endtask

    initial begin
        logic h;
        start = 1'b1;
        repeat (3) begin
            @(negedge prog_clk);
            check("rst_ready", cfg_ready, 0);
            check("rst_head", ccff_head, 0);
            check("rst_shift_en", ccff_shift_en, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_bit_count", bit_count, 0);
        end
        start  = 1'b0;
        pReset = 1'b1;
        mon_en = 1'b1;
        repeat (3) begin
            @(negedge prog_clk);
            check("idle_busy", busy, 0);
            check("idle_ready", cfg_ready, 0);
        end

        // Directed load with a 5-cycle gap before the short final word.
        begin_load();
        send_word(32'hA5A5_F00F);
        for (int i = 0; i < 100 && !cfg_ready; i++) @(negedge prog_clk);
        h = ccff_head;
        repeat (5) begin
            check("gap_ready", cfg_ready, 1);
            check("gap_shift_en", ccff_shift_en, 0);
            check("gap_bit_count", bit_count, model_sent);
            check("gap_head", ccff_head, h);
            @(negedge prog_clk);
        end
        send_word(32'hC000_0000);
        finish_load();

        // Reset mid-load at bit 17.
        begin_load();
        send_word($urandom);
        for (int i = 0; i < 100 && bit_count != CNT_W'(17); i++) @(negedge prog_clk);
        check("reached_17", bit_count, 17);
        pReset = 1'b0;
        @(negedge prog_clk);
        pReset = 1'b1;
        check("abort_shift_en", ccff_shift_en, 0);
        check("abort_bit_count", bit_count, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", cfg_ready, 0);
        @(negedge prog_clk);
        check("abort_idle", busy, 0);
        random_load();

        // start pulsed during SHIFT is ignored.
        begin_load();
        send_word($urandom);
        check("mid_shift_en", ccff_shift_en, 1);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        send_word($urandom);
        finish_load();

        // start in DONE begins a new load directly.
        repeat (4) random_load();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
